// File: rtl/waterlight_driver_if.sv
// -----------------------------------------------------------------------------
// waterlight_driver_if
//
// Groups the register-slave outputs feeding the LED driver and the driver's
// results into one bundle.
//
// Signals:
//   WaterLight_mode   [1:0]        00 rotate-left, 01 rotate-right/bounce,
//                                  10 flash, 11 off
//   WaterLight_speed  [CNT_W-1:0]  step period minus one, in HCLK cycles
//   led               [NUM_LED-1:0] registered LED drive, 1 = on
//   step_tick                      one-cycle pulse on every pattern step
//
// Modports:
//   master : register slave / bench side (drives mode and speed)
//   slave  : LED driver side (drives led and step_tick)
// -----------------------------------------------------------------------------
interface waterlight_driver_if #(
    parameter int NUM_LED = 8,
    parameter int CNT_W   = 32
);
    logic [1:0]         WaterLight_mode;
    logic [CNT_W-1:0]   WaterLight_speed;
    logic [NUM_LED-1:0] led;
    logic               step_tick;

    modport master (
        output WaterLight_mode,
        output WaterLight_speed,
        input  led,
        input  step_tick
    );

    modport slave (
        input  WaterLight_mode,
        input  WaterLight_speed,
        output led,
        output step_tick
    );
endinterface

// File: rtl/waterlight_driver.sv
// -----------------------------------------------------------------------------
// waterlight_driver
//
// LED pattern generator sitting directly behind the AHB-lite water-light
// register slave. A programmable prescaler produces a step every speed+1
// HCLK cycles; the pattern state machine (state = registered mode) applies
// one pattern step per prescaler expiry. Both share HCLK with the bus slave,
// so the mode/speed inputs are used without synchronisers.
//
// Ports:
//   HCLK     in   system clock
//   HRESETn  in   asynchronous active-low reset
//   bus      slave modport of waterlight_driver_if
//              WaterLight_mode / WaterLight_speed in, led / step_tick out
//
// Parameters:
//   NUM_LED  number of LED outputs, minimum 2
//   CNT_W    prescaler width, equal to the WaterLight_speed width
//
// Build option:
//   WATERLIGHT_PINGPONG_EN  when defined, mode 01 bounces between bit0 and
//                           bit NUM_LED-1 instead of rotating right.
// -----------------------------------------------------------------------------
module waterlight_driver #(
    parameter int NUM_LED = 8,
    parameter int CNT_W   = 32
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    waterlight_driver_if.slave  bus
);

    if (NUM_LED < 2) begin : g_bad_num_led
        $error("waterlight_driver: NUM_LED must be at least 2");
    end

    typedef enum logic [1:0] {
        MODE_ROT_L = 2'b00,
        MODE_ROT_R = 2'b01,
        MODE_FLASH = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    localparam logic [NUM_LED-1:0] LED_BIT0 = NUM_LED'(1);
    localparam logic [NUM_LED-1:0] LED_MSB  = {1'b1, {(NUM_LED-1){1'b0}}};
    localparam logic [NUM_LED-1:0] LED_ALL  = '1;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic is_one_hot(input logic [NUM_LED-1:0] v);
        return (v != '0) && ((v & (v - NUM_LED'(1))) == '0);
    endfunction

    function automatic logic [NUM_LED-1:0] init_pattern(input mode_e m);
        logic [NUM_LED-1:0] p;
        unique case (m)
            MODE_ROT_L: p = LED_BIT0;
`ifdef WATERLIGHT_PINGPONG_EN
            MODE_ROT_R: p = LED_BIT0;
`else
            MODE_ROT_R: p = LED_MSB;
`endif
            MODE_FLASH: p = LED_ALL;
            default:    p = '0;
        endcase
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               step_tick_q, step_tick_d;

    mode_e              mode_in;
    logic               mode_changed;
    logic               step;

    assign mode_in      = mode_e'(bus.WaterLight_mode);
    assign mode_changed = (mode_in != mode_q);
    // >= rather than == so a speed rewritten below the running count fires
    // on the next edge instead of waiting for the counter to wrap.
    assign step         = !mode_changed && (cnt_q >= bus.WaterLight_speed);

    // -------------------------------------------------------------------------
    // Process 1: state register (mode_q is the FSM state)
    // -------------------------------------------------------------------------
    // NOTE: clocked processes use non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            // Off matches the upstream reset value of the mode register, so
            // nothing lights up after reset until software writes a mode.
            mode_q <= MODE_OFF;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q       <= '0;
            led_q       <= '0;
            step_tick_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            led_q       <= led_d;
            step_tick_q <= step_tick_d;
        end
    end

`ifdef WATERLIGHT_PINGPONG_EN
    logic dir_q, dir_d;   // 0 = moving toward MSB, 1 = moving toward bit0

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Process 2: next-state logic (mode and prescaler)
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q + CNT_W'(1);
        if (mode_changed) begin
            // A mode change restarts the phase of the new pattern.
            mode_d = mode_in;
            cnt_d  = '0;
        end else if (step) begin
            // Clearing at the limit means the counter never has to pass
            // 2^CNT_W-1, even with speed at all ones.
            cnt_d  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Process 3: output logic (pattern and step pulse)
    // -------------------------------------------------------------------------
`ifdef WATERLIGHT_PINGPONG_EN
    logic               bounce_up;
    logic [NUM_LED-1:0] bounce_next;

    // The end positions force the direction, which keeps the pattern moving
    // even if dir and led were ever inconsistent.
    always_comb begin
        bounce_up = !dir_q;
        if (led_q[0]) begin
            bounce_up = 1'b1;
        end else if (led_q[NUM_LED-1]) begin
            bounce_up = 1'b0;
        end
        bounce_next = bounce_up ? (led_q << 1) : (led_q >> 1);
    end
`endif

    always_comb begin
        led_d       = led_q;
        step_tick_d = 1'b0;
`ifdef WATERLIGHT_PINGPONG_EN
        dir_d       = dir_q;
`endif
        if (mode_changed) begin
            led_d = init_pattern(mode_in);
`ifdef WATERLIGHT_PINGPONG_EN
            dir_d = 1'b0;
`endif
        end else if (step) begin
            step_tick_d = 1'b1;
            unique case (mode_q)
                MODE_ROT_L: begin
                    if (is_one_hot(led_q)) begin
                        led_d = {led_q[NUM_LED-2:0], led_q[NUM_LED-1]};
                    end else begin
                        led_d = init_pattern(MODE_ROT_L);
                    end
                end
                MODE_ROT_R: begin
`ifdef WATERLIGHT_PINGPONG_EN
                    if (is_one_hot(led_q)) begin
                        led_d = bounce_next;
                        if (bounce_next[NUM_LED-1]) begin
                            dir_d = 1'b1;
                        end else if (bounce_next[0]) begin
                            dir_d = 1'b0;
                        end else begin
                            dir_d = !bounce_up;
                        end
                    end else begin
                        led_d = init_pattern(MODE_ROT_R);
                        dir_d = 1'b0;
                    end
`else
                    if (is_one_hot(led_q)) begin
                        led_d = {led_q[0], led_q[NUM_LED-1:1]};
                    end else begin
                        led_d = init_pattern(MODE_ROT_R);
                    end
`endif
                end
                MODE_FLASH: led_d = ~led_q;
                default:    led_d = '0;
            endcase
        end
    end

    assign bus.led       = led_q;
    assign bus.step_tick = step_tick_q;

endmodule

// File: tb/tb_waterlight_driver.sv
// -----------------------------------------------------------------------------
// tb_waterlight_driver
//
// Directed bench for waterlight_driver (NUM_LED=8, CNT_W=32). A table of
// per-cycle records {mode, speed, expected led, expected step_tick} is built
// up front and replayed one clock edge per record; reset behaviour is covered
// by hand-written sequences around the table.
// Honours WATERLIGHT_PINGPONG_EN for the mode 01 expectations.
// -----------------------------------------------------------------------------
module tb_waterlight_driver;

    localparam int NUM_LED = 8;
    localparam int CNT_W   = 32;

    logic HCLK;
    logic HRESETn;

    waterlight_driver_if #(.NUM_LED(NUM_LED), .CNT_W(CNT_W)) bus_if ();

    waterlight_driver #(.NUM_LED(NUM_LED), .CNT_W(CNT_W)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus_if)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] speed;
        logic [7:0]  led;
        logic        tick;
    } vec_t;

    vec_t vec[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [1:0] m, input logic [31:0] s,
                                input logic [7:0] l, input logic t);
        vec_t v;
        v.mode = m; v.speed = s; v.led = l; v.tick = t;
        vec.push_back(v);
    endfunction

    task automatic tick_edge();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        logic [7:0] l;
        int         pos;
        bit         found;

        // ---------------- build the vector table ----------------
        // Mode 11, speed 5 straight out of reset: off, tick every 6 cycles.
        for (int r = 1; r <= 12; r++) add(2'b11, 32'd5, 8'h00, (r % 6) == 0);

        // Mode 00, speed 3: 01 one cycle later, then shift left every 4.
        add(2'b00, 32'd3, 8'h01, 1'b0);
        for (int s = 1; s <= 9; s++) begin
            l = 8'(1 << (s % 8));
            for (int k = 0; k < 3; k++) add(2'b00, 32'd3, 8'(1 << ((s - 1) % 8)), 1'b0);
            add(2'b00, 32'd3, l, 1'b1);
        end

        // Mode 01, speed 0: a step on every cycle after the load.
`ifdef WATERLIGHT_PINGPONG_EN
        add(2'b01, 32'd0, 8'h01, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            pos = (i % 14 <= 7) ? (i % 14) : (14 - (i % 14));
            add(2'b01, 32'd0, 8'(1 << pos), 1'b1);
        end
`else
        add(2'b01, 32'd0, 8'h80, 1'b0);
        for (int i = 1; i <= 9; i++) add(2'b01, 32'd0, 8'(8'h80 >> (i % 8)), 1'b1);
`endif

        // Mode 10, speed 1: FF, then toggling every 2 cycles.
        add(2'b10, 32'd1, 8'hFF, 1'b0);
        l = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            add(2'b10, 32'd1, l, 1'b0);
            l = ~l;
            add(2'b10, 32'd1, l, 1'b1);
        end

        // Mode 00, speed 100 run to cnt=60, then speed lowered to 10.
        add(2'b00, 32'd100, 8'h01, 1'b0);
        for (int k = 0; k < 60; k++) add(2'b00, 32'd100, 8'h01, 1'b0);
        add(2'b00, 32'd10, 8'h02, 1'b1);
        for (int k = 0; k < 10; k++) add(2'b00, 32'd10, 8'h02, 1'b0);
        add(2'b00, 32'd10, 8'h04, 1'b1);

        // Maximum speed value: no step for a long time, no wrap.
        for (int k = 0; k < 20; k++) add(2'b00, 32'hFFFF_FFFF, 8'h04, 1'b0);

        // Back to off.
        add(2'b11, 32'd5, 8'h00, 1'b0);
        add(2'b11, 32'd5, 8'h00, 1'b0);

        // ---------------- reset, held 50 cycles ----------------
        HRESETn = 1'b0;
        bus_if.WaterLight_mode  = 2'b11;
        bus_if.WaterLight_speed = 32'd5;
        #1;
        check("reset led", 32'(bus_if.led), 32'h00);
        check("reset tick", 32'(bus_if.step_tick), 32'h0);
        for (int c = 0; c < 50; c++) begin
            tick_edge();
            check($sformatf("reset hold led c%0d", c), 32'(bus_if.led), 32'h00);
        end
        HRESETn = 1'b1;

        // ---------------- table replay ----------------
        foreach (vec[i]) begin
            bus_if.WaterLight_mode  = vec[i].mode;
            bus_if.WaterLight_speed = vec[i].speed;
            tick_edge();
            check($sformatf("vec%0d led", i), 32'(bus_if.led), 32'(vec[i].led));
            check($sformatf("vec%0d tick", i), 32'(bus_if.step_tick), 32'(vec[i].tick));
        end

        // ---------------- async reset mid-pattern ----------------
        bus_if.WaterLight_mode  = 2'b00;
        bus_if.WaterLight_speed = 32'd2;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick_edge();
            if (bus_if.led == 8'h10) found = 1'b1;
        end
        check("reach led 10 within budget", 32'(found), 32'h1);
        check("tick with led 10", 32'(bus_if.step_tick), 32'h1);

        #2;
        HRESETn = 1'b0;
        bus_if.WaterLight_mode = 2'b11;
        #1;
        check("async reset led", 32'(bus_if.led), 32'h00);
        check("async reset tick", 32'(bus_if.step_tick), 32'h0);
        tick_edge();
        HRESETn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick_edge();
            check($sformatf("post reset led c%0d", c), 32'(bus_if.led), 32'h00);
        end

        bus_if.WaterLight_mode = 2'b00;
        tick_edge();
        check("restart led", 32'(bus_if.led), 32'h01);
        check("restart tick", 32'(bus_if.step_tick), 32'h0);
        tick_edge();
        check("restart hold led", 32'(bus_if.led), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
